ins_loader: RTL and testbench

//  Manual instruction-memory writer for the DE10-Lite MIPS lab. Drives the W_Ins/WE write port of SingleClockMIPS, which the

---
 rtl/ins_loader_pkg.sv | 16 +
 rtl/ins_loader_if.sv | 30 +++
 rtl/ins_loader.sv | 108 ++++++++++
 tb/tb_ins_loader.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ins_loader_pkg.sv
// Shared types and widths for the instruction-memory loader.
package ins_loader_pkg;

  localparam int unsigned NIB_W    = 4;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned WE_CNT_W = 4;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned DISP_W   = 16;

  typedef enum logic [1:0] {
    S_ENTRY = 2'd0,
    S_WRITE = 2'd1,
    S_ADV   = 2'd2
  } state_e;

endpackage

// File: rtl/ins_loader_if.sv
// Operator controls in, SingleClockMIPS write port and display status out.
interface ins_loader_if #(
  parameter int unsigned ADDR_W = 8
) ();
  import ins_loader_pkg::*;

  logic                LOAD_MODE;
  logic [NIB_W-1:0]    NIB_IN;
  logic                ENTER;
  logic                COMMIT;
  logic                CLEAR;
  logic                DISP_HI;
  logic [WORD_W-1:0]   W_Ins;
  logic                WE;
  logic [ADDR_W-1:0]   W_ADDR;
  logic [CNT_W-1:0]    NIB_CNT;
  logic [DISP_W-1:0]   DISP;
  logic                FULL;
  logic                ERR;

  modport master (
    output LOAD_MODE, NIB_IN, ENTER, COMMIT, CLEAR, DISP_HI,
    input  W_Ins, WE, W_ADDR, NIB_CNT, DISP, FULL, ERR
  );

  modport slave (
    input  LOAD_MODE, NIB_IN, ENTER, COMMIT, CLEAR, DISP_HI,
    output W_Ins, WE, W_ADDR, NIB_CNT, DISP, FULL, ERR
  );
endinterface

// File: rtl/ins_loader.sv
// Manual instruction-memory writer: nibble entry, commit, sequential word addresses.
// Optional macro INS_LOADER_AUTOCOMMIT_EN: the ENTER filling the last nibble starts the write.
module ins_loader
  import ins_loader_pkg::*;
#(
  parameter int unsigned NIBBLES   = 8,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned WE_CYCLES = 1
) (
  input  logic         CLK,
  input  logic         RST,
  ins_loader_if.slave  bus
);

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [CNT_W-1:0]    nib_cnt_q, nib_cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WE_CNT_W-1:0] we_cnt_q, we_cnt_d;
  logic                full_q;
  logic                we_q;
  logic [WORD_W-1:0]   w_ins_q;
  logic                err_q, err_d;

  // Next-state, assembly register and address counter
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    nib_cnt_d = nib_cnt_q;
    addr_d    = addr_q;
    we_cnt_d  = we_cnt_q;
    err_d     = 1'b0;
    case (state_q)
      S_ENTRY: begin
        if (bus.LOAD_MODE) begin
          if (bus.CLEAR) begin
            word_d    = '0;
            nib_cnt_d = '0;
          end else if (bus.COMMIT) begin
            if (full_q) begin
              state_d  = S_WRITE;
              we_cnt_d = '0;
            end else begin
              err_d = 1'b1;
            end
          end else if (bus.ENTER && !full_q) begin
            word_d    = {word_q[WORD_W-NIB_W-1:0], bus.NIB_IN};
            nib_cnt_d = nib_cnt_q + CNT_W'(1);
`ifdef INS_LOADER_AUTOCOMMIT_EN
            if (nib_cnt_q == CNT_W'(NIBBLES - 1)) begin
              state_d  = S_WRITE;
              we_cnt_d = '0;
            end
`endif
          end
        end
      end
      S_WRITE: begin
        if (we_cnt_q == WE_CNT_W'(WE_CYCLES - 1)) begin
          state_d = S_ADV;
        end else begin
          we_cnt_d = we_cnt_q + WE_CNT_W'(1);
        end
      end
      S_ADV: begin
        addr_d    = addr_q + ADDR_W'(1);
        word_d    = '0;
        nib_cnt_d = '0;
        state_d   = S_ENTRY;
      end
      default: state_d = S_ENTRY;
    endcase
  end

  // W_Ins is forced to zero outside WRITE so memory never sees stale data
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_ENTRY;
      word_q    <= '0;
      nib_cnt_q <= '0;
      addr_q    <= '0;
      we_cnt_q  <= '0;
      full_q    <= 1'b0;
      we_q      <= 1'b0;
      w_ins_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      nib_cnt_q <= nib_cnt_d;
      addr_q    <= addr_d;
      we_cnt_q  <= we_cnt_d;
      full_q    <= (nib_cnt_d == CNT_W'(NIBBLES));
      we_q      <= (state_d == S_WRITE);
      w_ins_q   <= (state_d == S_WRITE) ? word_d : '0;
      err_q     <= err_d;
    end
  end

  assign bus.W_Ins   = w_ins_q;
  assign bus.WE      = we_q;
  assign bus.W_ADDR  = addr_q;
  assign bus.NIB_CNT = nib_cnt_q;
  assign bus.FULL    = full_q;
  assign bus.ERR     = err_q;
  assign bus.DISP    = bus.DISP_HI ? word_q[WORD_W-1:DISP_W] : word_q[DISP_W-1:0];

endmodule

// File: tb/tb_ins_loader.sv
// Self-checking bench for ins_loader: directed scenarios plus random pulses against a behavioural model.
module tb_ins_loader;

  localparam int unsigned TB_ADDR_W    = 2;
  localparam int unsigned TB_WE_CYCLES = 2;
  localparam int unsigned TB_NIBBLES   = 8;

  logic CLK;
  logic RST;
  int   checks = 0;
  int   errors = 0;

  ins_loader_if #(.ADDR_W(TB_ADDR_W)) bus ();

  ins_loader #(
    .NIBBLES  (TB_NIBBLES),
    .ADDR_W   (TB_ADDR_W),
    .WE_CYCLES(TB_WE_CYCLES)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: word as a plain number, busy = cycles left before entry resumes
  logic [31:0] m_word;
  int          m_cnt, m_addr, m_busy;
  bit          m_err;

  initial begin
    m_word = 0; m_cnt = 0; m_addr = 0; m_busy = 0; m_err = 0;
    forever begin
      @(posedge CLK or negedge RST);
      if (!RST) begin
        m_word = 0; m_cnt = 0; m_addr = 0; m_busy = 0; m_err = 0;
      end else if (CLK) begin
        m_err = 0;
        if (m_busy == 1) begin
          m_addr = (m_addr + 1) % (1 << TB_ADDR_W);
          m_word = 0;
          m_cnt  = 0;
          m_busy = 0;
        end else if (m_busy > 1) begin
          m_busy = m_busy - 1;
        end else if (bus.LOAD_MODE) begin
          if (bus.CLEAR) begin
            m_word = 0;
            m_cnt  = 0;
          end else if (bus.COMMIT) begin
            if (m_cnt == TB_NIBBLES) m_busy = TB_WE_CYCLES + 1;
            else m_err = 1;
          end else if (bus.ENTER && m_cnt < TB_NIBBLES) begin
            m_word = (m_word << 4) | 32'(bus.NIB_IN);
            m_cnt  = m_cnt + 1;
`ifdef INS_LOADER_AUTOCOMMIT_EN
            if (m_cnt == TB_NIBBLES) m_busy = TB_WE_CYCLES + 1;
`endif
          end
        end
      end
    end
  end

  // Every cycle, away from the active edge
  always @(negedge CLK) begin
    logic        exp_we;
    logic [31:0] exp_disp;
    exp_we   = (m_busy > 1);
    exp_disp = bus.DISP_HI ? (m_word >> 16) : (m_word & 32'h0000_ffff);
    chk("model_we",      32'(bus.WE), 32'(exp_we));
    chk("model_w_ins",   bus.W_Ins, exp_we ? m_word : 32'h0);
    chk("model_w_addr",  32'(bus.W_ADDR), 32'(m_addr));
    chk("model_nib_cnt", 32'(bus.NIB_CNT), 32'(m_cnt));
    chk("model_full",    32'(bus.FULL), 32'(m_cnt == TB_NIBBLES));
    chk("model_err",     32'(bus.ERR), 32'(m_err));
    chk("model_disp",    32'(bus.DISP), exp_disp);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse(input bit e, input bit c, input bit cl, input logic [3:0] nib);
    bus.NIB_IN = nib;
    bus.ENTER  = e;
    bus.COMMIT = c;
    bus.CLEAR  = cl;
    tick();
    bus.ENTER  = 1'b0;
    bus.COMMIT = 1'b0;
    bus.CLEAR  = 1'b0;
  endtask

  // Enters a full word and starts its write; returns in the first WE cycle
  task automatic do_write(input logic [31:0] w);
    logic [31:0] tmp;
    tmp = w;
    pulse(0, 0, 1, 4'h0);
    for (int i = 7; i >= 0; i--) pulse(1, 0, 0, tmp[i*4 +: 4]);
`ifndef INS_LOADER_AUTOCOMMIT_EN
    pulse(0, 1, 0, 4'h0);
`endif
  endtask

  task automatic finish_write();
    repeat (TB_WE_CYCLES) tick();
    tick();
  endtask

  initial begin
    logic [3:0] nibs [8];
    nibs = '{4'h2, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h5};
    RST = 1'b0;
    bus.LOAD_MODE = 1'b1;
    bus.NIB_IN = '0; bus.ENTER = 0; bus.COMMIT = 0; bus.CLEAR = 0; bus.DISP_HI = 0;

    repeat (3) tick();
    chk("reset_we", 32'(bus.WE), 32'h0);
    chk("reset_w_ins", bus.W_Ins, 32'h0);
    chk("reset_addr", 32'(bus.W_ADDR), 32'h0);
    chk("reset_cnt", 32'(bus.NIB_CNT), 32'h0);
    chk("reset_err", 32'(bus.ERR), 32'h0);
    #3 RST = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) pulse(1, 0, 0, nibs[i]);
    pulse(1, 0, 0, nibs[7]);
`ifdef INS_LOADER_AUTOCOMMIT_EN
    chk("auto_we", 32'(bus.WE), 32'h1);
    chk("auto_w_ins", bus.W_Ins, 32'h2008_0005);
    chk("auto_addr", 32'(bus.W_ADDR), 32'h0);
`else
    chk("entry_full", 32'(bus.FULL), 32'h1);
    chk("entry_cnt", 32'(bus.NIB_CNT), 32'h8);
    chk("entry_disp_lo", 32'(bus.DISP), 32'h0005);
    chk("entry_no_we", 32'(bus.WE), 32'h0);
    bus.DISP_HI = 1'b1;
    #1 chk("entry_disp_hi", 32'(bus.DISP), 32'h2008);
    pulse(1, 0, 0, 4'hf);
    chk("ninth_enter_disp", 32'(bus.DISP), 32'h2008);
    chk("ninth_enter_cnt", 32'(bus.NIB_CNT), 32'h8);
    bus.DISP_HI = 1'b0;
    pulse(0, 1, 0, 4'h0);
    chk("commit_we", 32'(bus.WE), 32'h1);
    chk("commit_w_ins", bus.W_Ins, 32'h2008_0005);
    chk("commit_addr", 32'(bus.W_ADDR), 32'h0);
`endif
    repeat (TB_WE_CYCLES - 1) tick();
    chk("write_hold_we", 32'(bus.WE), 32'h1);
    tick();
    chk("adv_we", 32'(bus.WE), 32'h0);
    chk("adv_w_ins", bus.W_Ins, 32'h0);
    tick();
    chk("post_addr", 32'(bus.W_ADDR), 32'h1);
    chk("post_cnt", 32'(bus.NIB_CNT), 32'h0);
    chk("post_disp", 32'(bus.DISP), 32'h0);

    // Short commit is rejected
    for (int i = 1; i <= 3; i++) pulse(1, 0, 0, 4'(i));
    pulse(0, 1, 0, 4'h0);
    chk("short_err", 32'(bus.ERR), 32'h1);
    chk("short_no_we", 32'(bus.WE), 32'h0);
    chk("short_cnt", 32'(bus.NIB_CNT), 32'h3);
    tick();
    chk("short_err_pulse", 32'(bus.ERR), 32'h0);
    pulse(0, 0, 1, 4'h0);
    chk("clear_cnt", 32'(bus.NIB_CNT), 32'h0);

`ifndef INS_LOADER_AUTOCOMMIT_EN
    for (int i = 0; i < 8; i++) pulse(1, 0, 0, 4'h9);
    pulse(0, 1, 1, 4'h0);
    chk("clr_commit_cnt", 32'(bus.NIB_CNT), 32'h0);
    chk("clr_commit_we", 32'(bus.WE), 32'h0);
    tick();
    chk("clr_commit_we2", 32'(bus.WE), 32'h0);
`endif

    // Mode drop and ENTER during WRITE; address 1 -> 2
    do_write(32'hABCD_1234);
    chk("w2_w_ins", bus.W_Ins, 32'hABCD_1234);
    bus.LOAD_MODE = 1'b0;
    pulse(1, 0, 0, 4'h7);
    chk("w2_enter_ignored", bus.W_Ins, 32'hABCD_1234);
    finish_write();
    chk("w2_addr", 32'(bus.W_ADDR), 32'h2);

    pulse(1, 0, 0, 4'h3);
    pulse(0, 1, 0, 4'h0);
    chk("mode0_cnt", 32'(bus.NIB_CNT), 32'h0);
    chk("mode0_err", 32'(bus.ERR), 32'h0);
    bus.LOAD_MODE = 1'b1;

    do_write(32'h1111_2222);
    finish_write();
    chk("w3_addr", 32'(bus.W_ADDR), 32'h3);
    do_write(32'h3333_4444);
    finish_write();
    chk("wrap_addr", 32'(bus.W_ADDR), 32'h0);
    do_write(32'h5555_6666);
    finish_write();
    chk("w5_addr", 32'(bus.W_ADDR), 32'h1);

    // Asynchronous reset in the middle of a write
    do_write(32'hdead_beef);
    chk("pre_rst_we", 32'(bus.WE), 32'h1);
    #2 RST = 1'b0;
    #1;
    chk("async_rst_we", 32'(bus.WE), 32'h0);
    chk("async_rst_addr", 32'(bus.W_ADDR), 32'h0);
    chk("async_rst_cnt", 32'(bus.NIB_CNT), 32'h0);
    tick();
    #3 RST = 1'b1;
    tick();

    for (int n = 0; n < 4000; n++) begin
      bus.LOAD_MODE = ($urandom % 16) != 0;
      bus.ENTER     = ($urandom % 3) == 0;
      bus.COMMIT    = ($urandom % 6) == 0;
      bus.CLEAR     = ($urandom % 24) == 0;
      bus.NIB_IN    = 4'($urandom);
      bus.DISP_HI   = 1'($urandom);
      tick();
    end
    bus.ENTER = 0; bus.COMMIT = 0; bus.CLEAR = 0;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
